pixel_plot_queue: RTL
=====================

Name: pixel_plot_queue

Overview:
- Sits directly downstream of the instruction datapath. Captures its pixel strobes (x, y, colour, plot) into a small FIFO.
- Drains the FIFO into the VGA adapter write port at one pixel per accepted cycle.
- Decouples datapath plot bursts from adapter back-pressure and reports fill state so the controller can stall instruction issue.

Parameters:
- X_W, 8, x coordinate width (matches X_COORD_WIDTH)
- Y_W, 7, y coordinate width (matches Y_COORD_WIDTH)
- C_W, 3, colour width (matches COLOUR_WIDTH)
- DEPTH, 8, FIFO entries, power of two, >= 2
- SCREEN_W, 160, sweep width, used only with the optional feature
- SCREEN_H, 120, sweep height, used only with the optional feature

Ports:
- clock  in  1  single clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- plot  in  1  push strobe from datapath
- x  in  X_W  pixel x
- y  in  Y_W  pixel y
- colour  in  C_W  pixel colour
- full  out  1  FIFO full
- empty  out  1  FIFO empty
- count  out  $clog2(DEPTH+1)  occupancy
- overflow  out  1  sticky: a push was dropped
- clear_overflow  in  1  clears overflow
- vga_ready  in  1  adapter can accept a pixel this cycle
- vga_x  out  X_W  registered pixel x to adapter
- vga_y  out  Y_W  registered pixel y to adapter
- vga_colour  out  C_W  registered pixel colour to adapter
- vga_plot  out  1  registered one-cycle write enable to adapter

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - count=0, empty=1, full=0, overflow=0.
  - vga_x=0, vga_y=0, vga_colour=0, vga_plot=0.
  - Read and write pointers = 0. State = DRAIN.
- Push: when plot=1 and full=0 at the edge, {x,y,colour} is written at the write pointer and the pointer increments, wrapping modulo DEPTH.
- Dropped push: when plot=1 and full=1, the push is dropped and overflow is set to 1. This applies even if a pop occurs in the same cycle, so full is judged on the pre-edge count.
- Pop: when empty=0 and vga_ready=1 at the edge, the head entry loads into vga_x/vga_y/vga_colour, vga_plot<=1, and the read pointer increments, wrapping.
- No pop: vga_plot<=0 and vga_x/y/colour hold their last values.
- Simultaneous push and pop: count is unchanged.
- Status timing: full=(count==DEPTH) and empty=(count==0), both combinational from registered count.
- Latency: plot sampled at edge N into an empty queue, with vga_ready high, gives vga_plot=1 after edge N+1, i.e. 2 cycles. Throughput is 1 pixel/cycle.
- overflow: cleared by clear_overflow=1. If set and clear occur in the same edge, set wins.
- Ordering: FIFO order is strict. No reordering and no merging of duplicate coordinates.
- Reset mid-drain: the queue contents are discarded and vga_plot drops immediately.
- State machine (only 2 states when the optional feature is built):
  - DRAIN: normal operation as above.
  - CLEAR: see Optional Feature.

Optional Feature:
- Macro: PIXEL_QUEUE_CLEAR_EN.
- With the macro, extra ports are added:
  - clear_req in 1
  - clear_colour in C_W
  - busy out 1
- clear_req=1 latches a pending flag and samples clear_colour.
- When pending and empty=1, state goes DRAIN->CLEAR, pending is cleared and busy=1.
- In CLEAR, each vga_ready cycle emits (sx,sy,clear_colour) with vga_plot=1.
  - sx increments 0..SCREEN_W-1; at wrap, sx=0 and sy increments.
  - After (SCREEN_W-1,SCREEN_H-1) the state returns to DRAIN and busy=0.
  - Total of SCREEN_W*SCREEN_H pixels emitted.
- Pushes continue to enqueue during CLEAR (subject to full) and drain after it.
- clear_req during CLEAR sets pending; a second sweep follows.
- Reset: busy=0, pending=0.
- Without the macro: no extra ports and no CLEAR state. The queue always drains.

Decomposition:
- Shared package: coordinate, colour and pixel-record widths; packed pixel record {x,y,colour}; default DEPTH; screen dimensions; FIFO state encodings.
- One natural sub-module: pixel_fifo, a generic synchronous FIFO with DEPTH x (X_W+Y_W+C_W) storage, push, pop, full, empty and count.
- pixel_plot_queue wraps pixel_fifo with the output register, overflow flag and the optional sweep FSM.

Test Plan:
- Single pixel: plot=1 with (20,20,3'b110) for one cycle, vga_ready=1 -> vga_plot=1 exactly one cycle, 2 cycles later, vga_x=20, vga_y=20, vga_colour=6; then empty=1.
- Fill/stall: vga_ready=0, push 8 distinct pixels -> full=1, count=8. Push a 9th -> overflow=1, count stays 8. Raise vga_ready -> 8 pixels out in push order on 8 consecutive cycles, 9th absent.
- Concurrent push/pop at full: count=8, vga_ready=1, plot=1 -> push dropped, overflow=1, count=7.
- Pointer wrap: stream 20 pixels with vga_ready toggling every cycle -> all 20 emitted in order, no loss, count returns to 0.
- Async reset mid-drain: 4 queued, resetn low between edges -> vga_plot=0, empty=1 and overflow=0 immediately, without waiting for a clock edge.
- (CLEAR_EN) clear_req with clear_colour=0 plus one queued pixel -> queued pixel emitted first, then 19200 pixels (0,0)..(159,119) with colour 0, busy high throughout, then busy=0.

Source files
------------

// File: rtl/pixel_plot_queue_pkg.sv
// pixel_plot_queue_pkg: shared widths, pixel record, screen size and state encodings
package pixel_plot_queue_pkg;
  localparam int X_W_DEF      = 8;
  localparam int Y_W_DEF      = 7;
  localparam int C_W_DEF      = 3;
  localparam int PIX_W_DEF    = X_W_DEF + Y_W_DEF + C_W_DEF;
  localparam int DEPTH_DEF    = 8;
  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam logic [0:0] ST_DRAIN = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  typedef struct packed {
    logic [X_W_DEF-1:0] x;
    logic [Y_W_DEF-1:0] y;
    logic [C_W_DEF-1:0] colour;
  } pixel_t;
endpackage

// File: rtl/pixel_plot_queue_fifo.sv
// pixel_fifo: generic synchronous FIFO; pushes into a full queue and pops from an empty one are ignored
module pixel_fifo
  import pixel_plot_queue_pkg::*;
#(
  parameter int W = PIX_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic          w_push, w_pop;
  assign full   = count == CW'(DEPTH);
  assign empty  = count == '0;
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rd];
  always_ff @(posedge clock) if (w_push) r_mem[r_wr] <= din;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      r_wr  <= '0;
      r_rd  <= '0;
      count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      count <= count + CW'(w_push) - CW'(w_pop);
    end
endmodule

// File: rtl/pixel_plot_queue.sv
// pixel_plot_queue: buffers datapath pixel strobes and drains them to the VGA write port
// PIXEL_QUEUE_CLEAR_EN adds a full-screen clear sweep (clear_req/clear_colour/busy)
module pixel_plot_queue
  import pixel_plot_queue_pkg::*;
#(
  parameter int X_W = X_W_DEF,
  parameter int Y_W = Y_W_DEF,
  parameter int C_W = C_W_DEF,
  parameter int DEPTH = DEPTH_DEF
`ifdef PIXEL_QUEUE_CLEAR_EN
  , parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
`endif
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       plot,
  input  logic [X_W-1:0]             x,
  input  logic [Y_W-1:0]             y,
  input  logic [C_W-1:0]             colour,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  input  logic                       clear_overflow,
  input  logic                       vga_ready,
  output logic [X_W-1:0]             vga_x,
  output logic [Y_W-1:0]             vga_y,
  output logic [C_W-1:0]             vga_colour,
  output logic                       vga_plot
`ifdef PIXEL_QUEUE_CLEAR_EN
  , input  logic                     clear_req,
  input  logic [C_W-1:0]             clear_colour,
  output logic                       busy
`endif
);
  localparam int PW = X_W + Y_W + C_W;
  logic          w_pop, w_sweep;
  logic [PW-1:0] w_head, w_sweep_pix;
  pixel_fifo #(.W(PW), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .resetn(resetn),
    .push  (plot),
    .pop   (w_pop),
    .din   ({x, y, colour}),
    .dout  (w_head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
`ifdef PIXEL_QUEUE_CLEAR_EN
  localparam logic [X_W-1:0] SX_MAX = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] SY_MAX = Y_W'(SCREEN_H - 1);
  logic [0:0]     r_state;
  logic           r_pend;
  logic [C_W-1:0] r_pend_c, r_sweep_c;
  logic [X_W-1:0] r_sx;
  logic [Y_W-1:0] r_sy;
  logic           w_enter, w_last;
  // the sweep only starts once everything queued before it has been drawn
  assign w_enter     = r_state == ST_DRAIN && r_pend && empty;
  assign w_sweep     = r_state == ST_CLEAR && vga_ready;
  assign w_last      = w_sweep && r_sx == SX_MAX && r_sy == SY_MAX;
  assign w_pop       = r_state == ST_DRAIN && vga_ready && !empty;
  assign w_sweep_pix = {r_sx, r_sy, r_sweep_c};
  assign busy        = r_state == ST_CLEAR;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      r_state   <= ST_DRAIN;
      r_pend    <= 1'b0;
      r_pend_c  <= '0;
      r_sweep_c <= '0;
      r_sx      <= '0;
      r_sy      <= '0;
    end else begin
      r_pend <= clear_req || (r_pend && !w_enter);
      if (clear_req) r_pend_c <= clear_colour;
      if (w_enter) begin
        r_state   <= ST_CLEAR;
        r_sweep_c <= r_pend_c;
      end else if (w_last) r_state <= ST_DRAIN;
      if (w_sweep) begin
        r_sx <= (r_sx == SX_MAX) ? '0 : r_sx + 1'b1;
        if (r_sx == SX_MAX) r_sy <= (r_sy == SY_MAX) ? '0 : r_sy + 1'b1;
      end
    end
`else
  assign w_pop       = vga_ready && !empty;
  assign w_sweep     = 1'b0;
  assign w_sweep_pix = '0;
`endif
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      vga_plot <= w_pop || w_sweep;
      if (w_pop) {vga_x, vga_y, vga_colour} <= w_head;
      else if (w_sweep) {vga_x, vga_y, vga_colour} <= w_sweep_pix;
    end
  // a dropped push outranks a simultaneous clear
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) overflow <= 1'b0;
    else overflow <= (plot && full) ? 1'b1 : clear_overflow ? 1'b0 : overflow;
endmodule
